// File: rtl/tl_ul_mem_responder_if.sv
// TileLink-UL A/D channel bundle between one requester and the memory responder.
// The master drives A and d_ready; the slave drives a_ready and the D response.
interface tl_ul_mem_responder_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
    );
endinterface

// File: rtl/tl_ul_mem_responder.sv
// Single-register TileLink-UL memory responder: writes commit on the accept edge,
// the response is registered and presented one cycle after acceptance.
module tl_ul_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 16
) (
    input logic                    clock,
    input logic                    reset_n,
    tl_ul_mem_responder_if.slave   tl
);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(4 * DEPTH);

    logic [31:0] mem_r [DEPTH];

    logic        full_r;
    logic [2:0]  d_opcode_r;
    logic [3:0]  d_size_r;
    logic [4:0]  d_source_r;
    logic        d_denied_r;
    logic        d_corrupt_r;
    logic [31:0] d_data_r;

    logic             accept_s;
    logic [31:0]      offset_s;
    logic             hit_s;
    logic             misalign_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_s;
    logic             we_s;
    logic [2:0]       nxt_opcode_s;
    logic             nxt_denied_s;
    logic             nxt_corrupt_s;
    logic [31:0]      nxt_data_s;
    logic             unused_s;

    assign tl.a_ready = !full_r || tl.d_ready;
    assign accept_s   = tl.a_valid && tl.a_ready;
    // Subtracting the base lets addresses below BASE_ADDR wrap high and miss.
    assign offset_s   = tl.a_address - BASE_ADDR;
    assign hit_s      = ({1'b0, offset_s} < SPAN);
    assign idx_s      = tl.a_address[IDX_W+1:2];
    assign err_s      = !hit_s || misalign_s;
    assign unused_s   = ^tl.a_param;

    // Alignment check; sizes above one word fall to default and are always errors.
    always_comb begin
        misalign_s = 1'b1;
        case (tl.a_size)
            4'd0:    misalign_s = 1'b0;
            4'd1:    misalign_s = tl.a_address[0];
            4'd2:    misalign_s = (tl.a_address[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    // Decode the A request into the next D response and the write enable.
    always_comb begin
        nxt_opcode_s  = 3'd0;
        nxt_denied_s  = 1'b0;
        nxt_corrupt_s = 1'b0;
        nxt_data_s    = 32'd0;
        we_s          = 1'b0;
        case (tl.a_opcode)
            3'd4: begin
                nxt_opcode_s = 3'd1;
                if (err_s) begin
                    nxt_denied_s  = 1'b1;
                    nxt_corrupt_s = 1'b1;
                end else begin
                    nxt_data_s = mem_r[idx_s];
                end
            end
            3'd0, 3'd1: begin
                nxt_opcode_s = 3'd0;
                nxt_denied_s = err_s;
                we_s         = !err_s && !tl.a_corrupt;
            end
            3'd2, 3'd3: begin
                nxt_opcode_s  = 3'd1;
                nxt_denied_s  = 1'b1;
                nxt_corrupt_s = 1'b1;
            end
            3'd5: begin
                nxt_opcode_s = 3'd2;
            end
            default: begin
                nxt_opcode_s = 3'd0;
                nxt_denied_s = 1'b1;
            end
        endcase
    end

    // Response register: load on accept, clear full on drain, hold under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_r      <= 1'b0;
            d_opcode_r  <= 3'd0;
            d_size_r    <= 4'd0;
            d_source_r  <= 5'd0;
            d_denied_r  <= 1'b0;
            d_corrupt_r <= 1'b0;
            d_data_r    <= 32'd0;
        end else if (accept_s) begin
            full_r      <= 1'b1;
            d_opcode_r  <= nxt_opcode_s;
            d_size_r    <= tl.a_size;
            d_source_r  <= tl.a_source;
            d_denied_r  <= nxt_denied_s;
            d_corrupt_r <= nxt_corrupt_s;
            d_data_r    <= nxt_data_s;
        end else if (tl.d_ready) begin
            full_r <= 1'b0;
        end
    end

    // Byte-lane memory write on the accept edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept_s && we_s && reset_n) begin
            for (int b = 0; b < 4; b++) begin
                if (tl.a_mask[b]) begin
                    mem_r[idx_s][8*b +: 8] <= tl.a_data[8*b +: 8];
                end
            end
        end
    end

    assign tl.d_valid   = full_r;
    assign tl.d_opcode  = d_opcode_r;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = d_size_r;
    assign tl.d_source  = d_source_r;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = d_denied_r;
    assign tl.d_corrupt = d_corrupt_r;
    assign tl.d_data    = d_data_r;
endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Directed bench for tl_ul_mem_responder (DEPTH 16, base 0): one task per scenario,
// responses compared as a packed D bundle against hand-computed values.
module tb_tl_ul_mem_responder;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    tl_ul_mem_responder_if bus ();

    tl_ul_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .tl      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {valid, opcode, param, size, source, sink, denied, corrupt, data}
    function automatic logic [49:0] dresp();
        return {bus.d_valid, bus.d_opcode, bus.d_param, bus.d_size, bus.d_source,
                bus.d_sink, bus.d_denied, bus.d_corrupt, bus.d_data};
    endfunction

    function automatic logic [49:0] exp_d(input logic v, input logic [2:0] op, input logic [3:0] sz,
                                          input logic [4:0] src, input logic den, input logic cor,
                                          input logic [31:0] dat);
        return {v, op, 2'b00, sz, src, 1'b0, den, cor, dat};
    endfunction

    // Presents one A beat from edge+1, waits (bounded) for acceptance, returns at edge+1.
    task automatic send_req(input logic [2:0] op, input logic [3:0] sz, input logic [4:0] src,
                            input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] dat,
                            input logic cor);
        logic acc;
        logic rdy;
        acc = 1'b0;
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_param   = 3'd0;
        bus.a_size    = sz;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = dat;
        bus.a_corrupt = cor;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            rdy = bus.a_ready;
            @(posedge clock);
            acc = rdy;
            #1;
        end
        bus.a_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout op=%0d addr=%h got a_ready=0 required 1", op, addr);
        end
    endtask

    task automatic test_reset();
        logic [49:0] e;
        reset_n = 1'b0;
        #3;
        e = exp_d(1'b0, 3'd0, 4'd0, 5'd0, 1'b0, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL reset_d got=%h exp=%h", dresp(), e); end
        total++;
        if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL reset_a_ready got=%b exp=1", bus.a_ready); end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", bus.d_valid); end
    endtask

    task automatic test_put_get();
        logic [49:0] e;
        send_req(3'd0, 4'd2, 5'd3, 32'h4, 4'hF, 32'hDEADBEEF, 1'b0);
        e = exp_d(1'b1, 3'd0, 4'd2, 5'd3, 1'b0, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL put_full_ack got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd2, 5'd5, 32'h4, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd5, 1'b0, 1'b0, 32'hDEADBEEF);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL get_after_put got=%h exp=%h", dresp(), e); end
        send_req(3'd0, 4'd2, 5'd1, 32'h0, 4'hF, 32'h11223344, 1'b0);
        send_req(3'd4, 4'd2, 5'd2, 32'h0, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd2, 1'b0, 1'b0, 32'h11223344);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL get_word0 got=%h exp=%h", dresp(), e); end
    endtask

    task automatic test_partial();
        logic [49:0] e;
        send_req(3'd1, 4'd2, 5'd4, 32'h4, 4'h2, 32'h0000AB00, 1'b0);
        e = exp_d(1'b1, 3'd0, 4'd2, 5'd4, 1'b0, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL partial_ack got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd2, 5'd4, 32'h4, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd4, 1'b0, 1'b0, 32'hDEADABEF);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL partial_read got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd1, 5'd6, 32'h6, 4'hC, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd1, 5'd6, 1'b0, 1'b0, 32'hDEADABEF);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL half_read got=%h exp=%h", dresp(), e); end
    endtask

    task automatic test_errors();
        logic [49:0] e;
        send_req(3'd4, 4'd2, 5'd7, 32'h40, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd7, 1'b1, 1'b1, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL get_out_of_range got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd2, 5'd8, 32'h2, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd8, 1'b1, 1'b1, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL get_misaligned got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd3, 5'd9, 32'h0, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd3, 5'd9, 1'b1, 1'b1, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL get_oversize got=%h exp=%h", dresp(), e); end
        send_req(3'd2, 4'd2, 5'd10, 32'h0, 4'hF, 32'hFFFFFFFF, 1'b0);
        total++;
        if ({bus.d_valid, bus.d_opcode, bus.d_denied, bus.d_corrupt, bus.d_source} !== {1'b1, 3'd1, 1'b1, 1'b1, 5'd10}) begin
            bad++;
            $display("FAIL arith_denied got=%h exp=%h", {bus.d_valid, bus.d_opcode, bus.d_denied, bus.d_corrupt, bus.d_source},
                     {1'b1, 3'd1, 1'b1, 1'b1, 5'd10});
        end
        send_req(3'd0, 4'd2, 5'd11, 32'h44, 4'hF, 32'hCAFEF00D, 1'b0);
        e = exp_d(1'b1, 3'd0, 4'd2, 5'd11, 1'b1, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL put_out_of_range got=%h exp=%h", dresp(), e); end
        send_req(3'd0, 4'd2, 5'd12, 32'h0, 4'hF, 32'h0, 1'b1);
        e = exp_d(1'b1, 3'd0, 4'd2, 5'd12, 1'b0, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL put_corrupt_ack got=%h exp=%h", dresp(), e); end
        send_req(3'd6, 4'd2, 5'd13, 32'h0, 4'hF, 32'h0, 1'b0);
        e = exp_d(1'b1, 3'd0, 4'd2, 5'd13, 1'b1, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL opcode6 got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd2, 5'd14, 32'h0, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd14, 1'b0, 1'b0, 32'h11223344);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL word0_unchanged got=%h exp=%h", dresp(), e); end
        send_req(3'd4, 4'd2, 5'd15, 32'h4, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd15, 1'b0, 1'b0, 32'hDEADABEF);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL word1_unchanged got=%h exp=%h", dresp(), e); end
    endtask

    task automatic test_intent();
        logic [49:0] e;
        send_req(3'd5, 4'd2, 5'd21, 32'h1000, 4'hF, 32'h12345678, 1'b0);
        e = exp_d(1'b1, 3'd2, 4'd2, 5'd21, 1'b0, 1'b0, 32'd0);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL intent_hintack got=%h exp=%h", dresp(), e); end
        send_req(3'd5, 4'd2, 5'd22, 32'h4, 4'hF, 32'h0, 1'b0);
        send_req(3'd4, 4'd2, 5'd23, 32'h4, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd23, 1'b0, 1'b0, 32'hDEADABEF);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL intent_no_effect got=%h exp=%h", dresp(), e); end
    endtask

    task automatic test_back_to_back();
        logic [49:0] e1;
        logic [49:0] e2;
        e1 = exp_d(1'b1, 3'd1, 4'd2, 5'd1, 1'b0, 1'b0, 32'hDEADABEF);
        e2 = exp_d(1'b1, 3'd1, 4'd2, 5'd2, 1'b0, 1'b0, 32'h11223344);
        @(posedge clock);
        #1;
        bus.d_ready   = 1'b0;
        bus.a_valid   = 1'b1;
        bus.a_opcode  = 3'd4;
        bus.a_size    = 4'd2;
        bus.a_source  = 5'd1;
        bus.a_address = 32'h4;
        @(posedge clock);
        #1;
        bus.a_source  = 5'd2;
        bus.a_address = 32'h0;
        total++;
        if (dresp() !== e1) begin bad++; $display("FAIL bp_first got=%h exp=%h", dresp(), e1); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            total++;
            if ({bus.a_ready, dresp()} !== {1'b0, e1}) begin
                bad++;
                $display("FAIL bp_hold%0d got=%h exp=%h", i, {bus.a_ready, dresp()}, {1'b0, e1});
            end
        end
        bus.d_ready = 1'b1;
        #1;
        total++;
        if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.a_ready); end
        @(posedge clock);
        #1;
        bus.a_valid = 1'b0;
        total++;
        if (dresp() !== e2) begin bad++; $display("FAIL bp_refill got=%h exp=%h", dresp(), e2); end
        @(posedge clock);
        #1;
        total++;
        if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL bp_no_duplicate got=%b exp=0", bus.d_valid); end
    endtask

    task automatic test_reset_mid();
        logic [49:0] e;
        bus.d_ready = 1'b0;
        send_req(3'd4, 4'd2, 5'd30, 32'h4, 4'hF, 32'd0, 1'b0);
        total++;
        if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", bus.d_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        e = exp_d(1'b0, 3'd0, 4'd0, 5'd0, 1'b0, 1'b0, 32'd0);
        total++;
        if ({bus.a_ready, dresp()} !== {1'b1, e}) begin
            bad++;
            $display("FAIL mid_async_clear got=%h exp=%h", {bus.a_ready, dresp()}, {1'b1, e});
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            total++;
            if ({bus.a_ready, bus.d_valid} !== 2'b10) begin
                bad++;
                $display("FAIL mid_no_stale%0d got=%b exp=10", i, {bus.a_ready, bus.d_valid});
            end
        end
        send_req(3'd4, 4'd2, 5'd31, 32'h4, 4'hF, 32'd0, 1'b0);
        e = exp_d(1'b1, 3'd1, 4'd2, 5'd31, 1'b0, 1'b0, 32'hDEADABEF);
        total++;
        if (dresp() !== e) begin bad++; $display("FAIL mem_survives_reset got=%h exp=%h", dresp(), e); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        bus.a_valid   = 1'b0;
        bus.a_opcode  = 3'd0;
        bus.a_param   = 3'd0;
        bus.a_size    = 4'd0;
        bus.a_source  = 5'd0;
        bus.a_address = 32'd0;
        bus.a_mask    = 4'd0;
        bus.a_data    = 32'd0;
        bus.a_corrupt = 1'b0;
        bus.d_ready   = 1'b1;
        test_reset();
        test_put_get();
        test_partial();
        test_errors();
        test_intent();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tl_ul_mem_responder.md
TL_UL_MEM_RESPONDER -- requirements
Module: tl_ul_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of 32-bit words (power of 2, 2..256).
REQ-003 SHALL have port clock, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port a_valid, input, 1: A request valid.
REQ-006 SHALL have port a_ready, output, 1: A request accepted when a_valid&&a_ready.
REQ-007 SHALL have ports a_opcode (input, 3) and a_param (input, 3): A opcode and param; a_param is ignored.
REQ-008 SHALL have ports a_size (input, 4) and a_source (input, 5): log2 bytes and requester ID.
REQ-009 SHALL have ports a_address (input, 32), a_mask (input, 4), a_data (input, 32) and a_corrupt (input, 1): A address, byte lanes, write data and corrupt flag.
REQ-010 SHALL have ports d_valid (output, 1) and d_ready (input, 1): D response handshake.
REQ-011 SHALL have ports d_opcode (output, 3), d_param (output, 2) and d_size (output, 4): D opcode, param and echoed size.
REQ-012 SHALL have ports d_source (output, 5) and d_sink (output, 1): echoed a_source and sink ID, constant 0.
REQ-013 SHALL have ports d_denied (output, 1), d_data (output, 32) and d_corrupt (output, 1): error flag, read data and corrupt flag.

Function
REQ-014 SHALL hold one response register (full flag + D fields); a_ready = !full || d_ready (same-cycle drain and refill allowed).
REQ-015 SHALL, on A fire, load the response register at the next clock edge; d_valid asserts the cycle after acceptance (latency 1).
REQ-016 SHALL keep all D outputs stable while d_valid && !d_ready; full clears on d_ready with no new A fire.
REQ-017 SHALL compute hit = a_address in [BASE_ADDR, BASE_ADDR+4*DEPTH), with the word index taken from a_address[log2(DEPTH)+1:2].
REQ-018 SHALL set err = !hit || a_size>2 || a_address not aligned to 2^a_size.
REQ-019 SHALL, for Get (4) with !err, return d_opcode=1 (AccessAckData) and d_data = the word read at acceptance.
REQ-020 SHALL, for PutFull (0) and PutPartial (1) with !err && !a_corrupt, write the bytes enabled by a_mask on the accept edge and return d_opcode=0 (AccessAck).
REQ-021 SHALL, for a Put with a_corrupt=1, suppress the write and return AccessAck with d_denied=0.
REQ-022 SHALL, for Arithmetic (2) and Logical (3), suppress the write and return AccessAckData with d_denied=1 and d_corrupt=1.
REQ-023 SHALL, for Intent (5), return HintAck (d_opcode=2) with d_denied=0 and no memory effect.
REQ-024 SHALL, for an err on Get/Put, return the normal opcode with d_denied=1, set d_corrupt=1 only on AccessAckData, and leave memory unchanged.
REQ-025 SHALL drive d_param=0, d_sink=0 and d_size=a_size always; d_data=0 on all non-AccessAckData responses.
REQ-026 SHALL, for opcodes 6 and 7, return AccessAck with d_denied=1.
REQ-027 SHALL make a Get accepted in the same cycle a Put drains see memory state including all earlier accepted Puts (no read-after-write hazard, since writes commit on the accept edge).

Reset
REQ-028 SHALL, on reset_n low, immediately clear full (d_valid=0) and drive D fields to 0, without waiting for a clock edge.
REQ-029 SHALL force a_ready=1 out of reset; memory contents are not reset.
REQ-030 SHALL discard a pending response when reset asserts mid-transfer; no response is issued after deassertion.

Verification
REQ-031 Put then Get: PutFull 0x4 data 0xDEADBEEF mask 0xF src 3, then Get 0x4 size 2 -> AccessAck src 3, then AccessAckData 0xDEADBEEF denied 0.
REQ-032 Partial write: PutPartial 0x4 mask 0x2 data 0x0000AB00 over 0xDEADBEEF, then Get -> 0xDEADABEF.
REQ-033 Errors: Get 0x40 (DEPTH 16) -> denied 1, corrupt 1, data 0; Get 0x2 size 2 -> denied 1; Arithmetic 0x0 -> AccessAckData denied 1, memory unchanged.
REQ-034 Backpressure: d_ready=0 for 5 cycles with back-to-back A -> one accepted, a_ready=0, D fields stable; d_ready=1 -> drain, refill in the same cycle, no loss or duplication.
REQ-035 Reset: assert reset_n=0 while d_valid=1 -> d_valid=0 asynchronously; after release, a_ready=1 and no stale response.
REQ-036 Intent at any address -> HintAck, denied 0, d_source echoed, memory unchanged.
